// File: rtl/multisim_pkg.sv
// Shared constants and types for the multisim transport receive path.
// Frames are one ID byte followed by eight payload bytes, least-significant first.
package multisim_pkg;

    localparam int WORD_W      = 64;
    localparam int BYTE_W      = 8;
    localparam int FRAME_BYTES = 8;
    localparam int ID_W        = 8;
    localparam int BCNT_W      = $clog2(FRAME_BYTES);

    typedef enum logic {S_ID, S_DATA} rx_state_t;

endpackage

// File: rtl/multisim_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rdata_o whenever non-empty.
// Pushes while full and pops while empty are ignored.
module multisim_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/multisim_server_core.sv
// Receive endpoint: parses ID-tagged 9-byte frames, keeps those for this server,
// buffers the assembled 64-bit words and counts discarded frames.
module multisim_server_core
    import multisim_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   server_id,
    input  logic              rx_vld,
    input  logic [BYTE_W-1:0] rx_byte,
    output logic              rx_rdy,
    input  logic              data_rdy,
    output logic              data_vld,
    output logic [WORD_W-1:0] data,
    output logic [CNT_W-1:0]  drop_cnt
);

    // The eighth payload byte goes straight into the FIFO, so only seven are held.
    localparam int ASM_W = WORD_W - BYTE_W;

    rx_state_t         state_q, state_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic              match_q, match_d;
    logic [ASM_W-1:0]  asm_q, asm_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic              last_byte;
    logic              accept;
    logic              push;
    logic              drop_inc;
    logic              fifo_full, fifo_empty;
    logic [WORD_W-1:0] word;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign last_byte = (state_q == S_DATA) && (cnt_q == BCNT_W'(FRAME_BYTES - 1));
    assign word      = {rx_byte, asm_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ID;
            cnt_q   <= '0;
            match_q <= 1'b0;
            asm_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            asm_q   <= asm_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ID:    if (accept) state_d = S_DATA;
            S_DATA:  if (accept && last_byte) state_d = S_ID;
            default: state_d = S_ID;
        endcase
    end

    // Only a matching frame whose last byte finds the FIFO full is ever stalled.
    always_comb begin
        rx_rdy   = !(last_byte && match_q && fifo_full);
        accept   = rx_vld && rx_rdy;
        push     = accept && last_byte && match_q;
        drop_inc = accept && last_byte && !match_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        match_d = match_q;
        asm_d   = asm_q;
        drop_d  = drop_inc ? sat_inc(drop_q) : drop_q;
        if (accept) begin
            if (state_q == S_ID) begin
                cnt_d   = '0;
                match_d = (rx_byte == server_id);
            end else begin
                cnt_d = cnt_q + BCNT_W'(1);
                asm_d = {rx_byte, asm_q[ASM_W-1:BYTE_W]};
            end
        end
    end

    multisim_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (word),
        .pop_i   (data_rdy),
        .rdata_o (data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign data_vld = !fifo_empty;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_multisim_server_core.sv
// Directed bench for multisim_server_core; a second instance with a 2-bit drop
// counter follows the same accepted byte stream to exercise saturation.
module tb_multisim_server_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  server_id;
    logic        rx_vld;
    logic [7:0]  rx_byte;
    logic        rx_rdy;
    logic        man_rdy, rnd_rdy, rand_en;
    logic        data_rdy;
    logic        data_vld;
    logic [63:0] data;
    logic [15:0] drop_cnt;

    logic        rx_vld2;
    logic        rx_rdy2;
    logic        data_vld2;
    logic [63:0] data2;
    logic [1:0]  drop_cnt2;

    int          checks = 0;
    int          errors = 0;
    int          stalls = 0;
    logic [63:0] got [$];

    assign data_rdy = rand_en ? rnd_rdy : man_rdy;
    assign rx_vld2  = rx_vld && rx_rdy;

    always #5 clk = ~clk;

    multisim_server_core #(.DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .server_id (server_id),
        .rx_vld    (rx_vld),
        .rx_byte   (rx_byte),
        .rx_rdy    (rx_rdy),
        .data_rdy  (data_rdy),
        .data_vld  (data_vld),
        .data      (data),
        .drop_cnt  (drop_cnt)
    );

    multisim_server_core #(.DEPTH(4), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .server_id (server_id),
        .rx_vld    (rx_vld2),
        .rx_byte   (rx_byte),
        .rx_rdy    (rx_rdy2),
        .data_rdy  (1'b1),
        .data_vld  (data_vld2),
        .data      (data2),
        .drop_cnt  (drop_cnt2)
    );

    always @(posedge clk) begin
        if (rst_n && data_vld && data_rdy) got.push_back(data);
    end

    always begin
        @(posedge clk);
        #1;
        rnd_rdy = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        rx_vld = 1'b0;
        repeat (gap) tick();
        rx_vld  = 1'b1;
        rx_byte = b;
        while (!rx_rdy && waited < 200) begin
            stalls++;
            tick();
            waited++;
        end
        if (waited >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout observed=stalled expected=accepted");
        end
        tick();
        rx_vld = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [63:0] w, input int maxgap);
        send_byte(id, int'($urandom_range(0, maxgap)));
        for (int k = 0; k < 8; k++) send_byte(w[8*k +: 8], int'($urandom_range(0, maxgap)));
    endtask

    task automatic wait_got(input int n);
        int t = 0;
        while (got.size() < n && t < 2000) begin
            tick();
            t++;
        end
    endtask

    initial begin
        int          base;
        int          nmis;
        logic [15:0] d0;
        logic [63:0] p;
        logic [63:0] w5;
        logic [63:0] expq [$];

        rst_n     = 1'b0;
        rx_vld    = 1'b0;
        rx_byte   = 8'h00;
        server_id = 8'h03;
        man_rdy   = 1'b0;
        rand_en   = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_data_vld", 64'(data_vld), 64'd0);
        chk("rst_data", data, 64'd0);
        chk("rst_rx_rdy", 64'(rx_rdy), 64'd1);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_data_vld", 64'(data_vld), 64'd0);
        chk("idle_rx_rdy", 64'(rx_rdy), 64'd1);

        // Basic matching frame, byte order
        send_frame(8'h03, 64'hEFCDAB8967452301, 0);
        chk("basic_vld", 64'(data_vld), 64'd1);
        chk("basic_data", data, 64'hEFCDAB8967452301);
        man_rdy = 1'b1;
        tick();
        man_rdy = 1'b0;
        chk("basic_pop_vld", 64'(data_vld), 64'd0);
        chk("basic_pop_data", data, 64'd0);

        // Non-matching frame is dropped without back-pressure
        base = stalls;
        send_frame(8'h05, 64'hDEADBEEFCAFEF00D, 0);
        chk("mis_stalls", 64'(stalls - base), 64'd0);
        chk("mis_vld", 64'(data_vld), 64'd0);
        chk("mis_drop", 64'(drop_cnt), 64'd1);
        send_frame(8'h03, 64'h1122334455667788, 0);
        chk("after_mis_vld", 64'(data_vld), 64'd1);
        chk("after_mis_data", data, 64'h1122334455667788);
        man_rdy = 1'b1;
        tick();
        man_rdy = 1'b0;
        chk("after_mis_pop", 64'(data_vld), 64'd0);

        // Full FIFO stalls the 5th frame's last byte, with no full-bypass
        base = got.size();
        for (int i = 1; i <= 4; i++) send_frame(8'h03, 64'(i), 0);
        chk("full_head", data, 64'd1);
        w5 = 64'd5;
        send_byte(8'h03, 0);
        for (int k = 0; k < 7; k++) send_byte(w5[8*k +: 8], 0);
        rx_vld  = 1'b1;
        rx_byte = w5[63:56];
        chk("full_rdy_a", 64'(rx_rdy), 64'd0);
        tick();
        tick();
        chk("full_rdy_b", 64'(rx_rdy), 64'd0);
        man_rdy = 1'b1;
        chk("full_no_bypass", 64'(rx_rdy), 64'd0);
        tick();
        chk("full_after_pop", 64'(rx_rdy), 64'd1);
        tick();
        rx_vld = 1'b0;
        wait_got(base + 5);
        chk("full_count", 64'(got.size() - base), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < got.size()) chk("full_order", got[base+i], 64'(i + 1));
        end
        man_rdy = 1'b0;

        // Random gaps and back-pressure over mixed frames
        base    = got.size();
        nmis    = 0;
        d0      = drop_cnt;
        rand_en = 1'b1;
        for (int f = 0; f < 200; f++) begin
            p = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) begin
                send_frame(8'($urandom_range(4, 255)), p, 2);
                nmis++;
            end else begin
                expq.push_back(p);
                send_frame(8'h03, p, 2);
            end
        end
        rand_en = 1'b0;
        man_rdy = 1'b1;
        wait_got(base + expq.size());
        chk("rand_count", 64'(got.size() - base), 64'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            if (base + i < got.size()) chk("rand_word", got[base+i], expq[i]);
        end
        chk("rand_drop", 64'(drop_cnt), 64'(d0 + 16'(nmis)));
        man_rdy = 1'b0;
        tick();

        // Reset mid-frame discards the partial frame
        send_byte(8'h03, 0);
        for (int k = 0; k < 4; k++) send_byte(8'hA0 + 8'(k), 0);
        rst_n = 1'b0;
        tick();
        tick();
        chk("midrst_vld", 64'(data_vld), 64'd0);
        chk("midrst_drop", 64'(drop_cnt), 64'd0);
        chk("midrst_rdy", 64'(rx_rdy), 64'd1);
        rst_n = 1'b1;
        tick();
        send_frame(8'h03, 64'h0123456789ABCDEF, 0);
        chk("midrst_new_vld", 64'(data_vld), 64'd1);
        chk("midrst_new_data", data, 64'h0123456789ABCDEF);
        man_rdy = 1'b1;
        tick();
        man_rdy = 1'b0;
        chk("midrst_only_one", 64'(data_vld), 64'd0);

        // Drop counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) send_frame(8'h7E, 64'(i), 0);
        chk("sat_drop2", 64'(drop_cnt2), 64'd3);
        chk("sat_drop16", 64'(drop_cnt), 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multisim_server_core.md
Name: multisim_server_core

Overview:
- Receive endpoint of the multisim transport.
- Consumes a byte stream of framed 64-bit transactions from a link or serializer.
- Keeps only frames addressed to this server's runtime ID and buffers them in a small FIFO.
- Presents them to the local agent (e.g. a CPU stub) on a valid/ready word interface. One instance per server; the parent supplies the ID (e.g. CPU index).

Parameters:
- DEPTH, 4, FIFO depth in 64-bit words; power of 2, ≥2.
- CNT_W, 16, width of the dropped-frame counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- server_id  input  8  runtime server ID; sampled when a frame's ID byte is accepted.
- rx_vld  input  1  transport byte valid.
- rx_byte  input  8  transport byte.
- rx_rdy  output  1  byte accepted when rx_vld && rx_rdy.
- data_rdy  input  1  consumer ready.
- data_vld  output  1  word available.
- data  output  64  FIFO head word.
- drop_cnt  output  CNT_W  saturating count of frames discarded for ID mismatch.

Behaviour:
- Frame format: 9 bytes = 1 ID byte, then 8 payload bytes, least-significant first. Payload byte k maps to data[8k+7:8k].
- Parser FSM:
  - S_ID: on accept, latch match = (rx_byte == server_id), clear byte count, go to S_DATA.
  - S_DATA: on each accept, shift the byte into the 64-bit assembly register and increment the count 0..7. On the accept at count 7, return to S_ID.
- Completion at count 7:
  - match=1: the assembled word is pushed into the FIFO on that same edge.
  - match=0: nothing is pushed; drop_cnt increments, saturating at all-ones.
- rx_rdy = 0 only when state==S_DATA, count==7, match==1 and the FIFO is full. Otherwise rx_rdy = 1. Non-matching frames are never back-pressured.
- Full FIFO blocks the final byte even if data_rdy pops in the same cycle (no full-bypass).
- FIFO is show-ahead:
  - data_vld = !empty.
  - data = head entry when data_vld=1, else 64'h0.
  - Pop on data_vld && data_rdy.
  - Simultaneous push and pop on a non-empty, non-full FIFO keeps the occupancy unchanged.
- Latency: final payload byte accepted at edge N → data_vld=1 and data valid in the cycle after edge N. Empty-FIFO bypass is not provided.
- Ordering: words leave in frame-arrival order; no reordering or loss for matching frames.
- Idle bytes: rx_vld=0 cycles inside a frame simply stall the parser.
- server_id changes mid-frame have no effect on the current frame; only the value sampled at the ID byte counts.
- Reset (rst_n low, asynchronous):
  - state=S_ID, count=0, match=0, assembly register=0.
  - FIFO pointers and count cleared.
  - drop_cnt=0, data_vld=0, data=0, rx_rdy=1.
  - Reset mid-frame discards the partial frame. Reset is released synchronously to clk.
- rx_byte and data_rdy are ignored when not qualified by their valid/accept conditions.

Decomposition:
- Package multisim_pkg: WORD_W=64, BYTE_W=8, FRAME_BYTES=8, ID_W=8, typedef enum logic {S_ID, S_DATA} rx_state_t.
- One sub-module, multisim_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH, async active-low reset, outputs full/empty.
- Parser, assembly register and drop counter stay in multisim_server_core.

Test Plan:
- Reset then idle: data_vld=0, data=0, rx_rdy=1, drop_cnt=0.
- server_id=8'h03; send 03,01,23,45,67,89,AB,CD,EF back-to-back → one cycle after the last byte, data_vld=1, data=64'hEFCDAB8967452301. Pops with data_rdy=1, after which data_vld=0.
- server_id=8'h03; send ID 05 + 8 bytes → no data_vld, drop_cnt=1, rx_rdy stays 1 throughout. A following ID-03 frame is delivered normally.
- DEPTH=4, data_rdy=0; send 5 matching frames with payloads 1..5 →
  - after 4 frames, rx_rdy=0 while the 5th frame's last byte is presented;
  - raise data_rdy → words 1,2,3,4,5 come out in order; the 5th is accepted only after the first pop.
- Random rx_vld gaps and random data_rdy over 200 mixed matching/non-matching frames → scoreboard matches payloads exactly; drop_cnt equals the number of mismatched frames.
- Assert rst_n low after 4 payload bytes of a matching frame, then send a full new frame → only the new frame's word is delivered. Also check drop_cnt saturation with CNT_W=2 after 5 mismatched frames → 3.
